// File: rtl/can_apb_bridge_mc_if.sv
// APB3/APB4 slave-side bus bundle for can_apb_bridge_mc.
// Member names drop the s_apb_ prefix; the instance is named s_apb, so s_apb.paddr is s_apb_paddr.
interface can_apb_bridge_mc_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/can_apb_bridge_mc.sv
// APB to multi-channel CAN register bridge: serialises each 32-bit access into
// byte strobes on one of NUM_CH 8-bit register ports and aggregates channel irqs.
// Optional IRQ pending/mask window enabled by defining CAN_APB_IRQ_CTRL_EN.
module can_apb_bridge_mc #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned CH_WIN_LOG2 = 10,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic                  aclk,
  input  logic                  arst,
  can_apb_bridge_mc_if.slave    s_apb,
  output logic [NUM_CH-1:0]     reg_we_o,
  output logic [NUM_CH-1:0]     reg_re_o,
  output logic [ADDR_W-1:0]     reg_addr_o,
  output logic [7:0]            reg_wdata_o,
  input  logic [NUM_CH*8-1:0]   reg_rdata_i,
  input  logic [NUM_CH-1:0]     irq_ch_i,
  output logic                  irq_o
);

  localparam int unsigned CH_W  = 4;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BYTE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CH_W-1:0]     r_ch;
  logic [ADDR_W-1:0]   r_base;
  logic [31:0]         r_wdata;
  logic [3:0]          r_pend;
  logic [1:0]          r_lane;
  logic [CNT_W-1:0]    r_cnt;
  logic [23:0]         r_rdbuf;
  logic [NUM_CH-1:0]   r_we;
  logic [NUM_CH-1:0]   r_re;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wbyte;
  logic [31:0]         r_prdata;
  logic                r_pready;
  logic                r_pslverr;
  logic                r_irq;
`ifdef CAN_APB_IRQ_CTRL_EN
  localparam int unsigned OFF_W = CH_WIN_LOG2 - 2;
  logic [NUM_CH-1:0]   r_mask;
  logic [OFF_W-1:0]    w_off;
  assign w_off = s_apb.paddr[CH_WIN_LOG2-1:2];
`endif

  logic                w_access;
  logic [CH_W-1:0]     w_ch;
  logic [ADDR_W-1:0]   w_base;
  logic [NUM_CH-1:0]   w_ch_oh;
  logic [NUM_CH-1:0]   w_rch_oh;
  logic                w_is_ch;
  logic [1:0]          w_first_lane;
  logic [1:0]          w_next_lane;
  logic [7:0]          w_rd_byte;
  logic                w_unused;

  // Lowest set lane of a 4-bit strobe mask
  function automatic logic [1:0] f_first(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Byte lane l of a 32-bit word
  function automatic logic [7:0] f_byte(input logic [31:0] d, input logic [1:0] l);
    case (l)
      2'd0:    return d[7:0];
      2'd1:    return d[15:8];
      2'd2:    return d[23:16];
      default: return d[31:24];
    endcase
  endfunction

  assign w_access     = s_apb.psel & s_apb.penable;
  assign w_ch         = s_apb.paddr[CH_WIN_LOG2+3:CH_WIN_LOG2];
  assign w_base       = {s_apb.paddr[ADDR_W-1:2], 2'b00};
  assign w_ch_oh      = NUM_CH'(1) << w_ch;
  assign w_rch_oh     = NUM_CH'(1) << r_ch;
  assign w_is_ch      = (w_ch < CH_W'(NUM_CH));
  assign w_first_lane = f_first(s_apb.pstrb);
  assign w_next_lane  = f_first(r_pend);
  assign w_unused     = &{1'b0, s_apb.pprot, s_apb.paddr};

  // Select the read byte of the latched channel
  always_comb begin
    w_rd_byte = 8'h00;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (r_ch == CH_W'(c)) w_rd_byte = reg_rdata_i[8*c +: 8];
    end
  end

  // Transfer sequencer with registered strobes and APB response
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_base    <= '0;
      r_wdata   <= '0;
      r_pend    <= '0;
      r_lane    <= '0;
      r_cnt     <= '0;
      r_rdbuf   <= '0;
      r_we      <= '0;
      r_re      <= '0;
      r_addr    <= '0;
      r_wbyte   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_ch    <= w_ch;
            r_base  <= w_base;
            r_wdata <= s_apb.pwdata;
            if (w_is_ch) begin
              if (s_apb.pwrite) begin
                if (s_apb.pstrb == 4'b0000) begin
                  r_state  <= S_DONE;
                  r_pready <= 1'b1;
                end else begin
                  r_state <= S_WR_BYTE;
                  r_we    <= w_ch_oh;
                  r_addr  <= w_base | ADDR_W'(w_first_lane);
                  r_wbyte <= f_byte(s_apb.pwdata, w_first_lane);
                  r_pend  <= s_apb.pstrb & ~(4'b0001 << w_first_lane);
                end
              end else begin
                r_state <= S_RD_ISSUE;
                r_re    <= w_ch_oh;
                r_addr  <= w_base;
                r_lane  <= 2'd0;
              end
            end
`ifdef CAN_APB_IRQ_CTRL_EN
            else if (w_ch == CH_W'(NUM_CH)) begin
              r_state  <= S_DONE;
              r_pready <= 1'b1;
              if (!s_apb.pwrite) begin
                if (w_off == OFF_W'(0))      r_prdata <= 32'(irq_ch_i);
                else if (w_off == OFF_W'(1)) r_prdata <= 32'(r_mask);
                else                         r_prdata <= '0;
              end
            end
`endif
            else begin
              r_state   <= S_DONE;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
            end
          end
        end
        S_WR_BYTE: begin
          if (r_pend == 4'b0000) begin
            r_state  <= S_DONE;
            r_we     <= '0;
            r_addr   <= '0;
            r_wbyte  <= '0;
            r_pready <= 1'b1;
          end else begin
            r_addr  <= r_base | ADDR_W'(w_next_lane);
            r_wbyte <= f_byte(r_wdata, w_next_lane);
            r_pend  <= r_pend & ~(4'b0001 << w_next_lane);
          end
        end
        S_RD_ISSUE: begin
          r_state <= S_RD_WAIT;
          r_re    <= '0;
          r_addr  <= '0;
          r_cnt   <= CNT_W'(RD_LAT - 1);
        end
        S_RD_WAIT: begin
          if (r_cnt == '0) begin
            if (r_lane == 2'd3) begin
              r_state  <= S_DONE;
              r_pready <= 1'b1;
              r_prdata <= {w_rd_byte, r_rdbuf};
            end else begin
              case (r_lane)
                2'd0:    r_rdbuf[7:0]   <= w_rd_byte;
                2'd1:    r_rdbuf[15:8]  <= w_rd_byte;
                default: r_rdbuf[23:16] <= w_rd_byte;
              endcase
              r_state <= S_RD_ISSUE;
              r_lane  <= r_lane + 2'd1;
              r_re    <= w_rch_oh;
              r_addr  <= r_base | ADDR_W'(r_lane + 2'd1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CAN_APB_IRQ_CTRL_EN
  // MASK register, byte 0 write strobe only covers the used bits
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_mask <= '1;
    end else if (r_state == S_IDLE && w_access && s_apb.pwrite &&
                 w_ch == CH_W'(NUM_CH) && w_off == OFF_W'(1) && s_apb.pstrb[0]) begin
      r_mask <= s_apb.pwdata[NUM_CH-1:0];
    end
  end

  // Registered masked interrupt aggregate
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) r_irq <= 1'b0;
    else      r_irq <= |(irq_ch_i & r_mask);
  end
`else
  // Registered plain interrupt aggregate
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) r_irq <= 1'b0;
    else      r_irq <= |irq_ch_i;
  end
`endif

  assign reg_we_o      = r_we;
  assign reg_re_o      = r_re;
  assign reg_addr_o    = r_addr;
  assign reg_wdata_o   = r_wbyte;
  assign s_apb.prdata  = r_prdata;
  assign s_apb.pready  = r_pready;
  assign s_apb.pslverr = r_pslverr;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_can_apb_bridge_mc.sv
// Directed bench for can_apb_bridge_mc (NUM_CH=2, RD_LAT=2).
// Register model: channel 0 returns addr^0x5A, channel 1 addr^0xA5, valid exactly RD_LAT cycles after reg_re_o.
module tb_can_apb_bridge_mc;
  localparam int unsigned NUM_CH      = 2;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned CH_WIN_LOG2 = 10;
  localparam int unsigned RD_LAT      = 2;

  logic                  aclk = 1'b0;
  logic                  arst;
  logic [NUM_CH-1:0]     reg_we_o;
  logic [NUM_CH-1:0]     reg_re_o;
  logic [ADDR_W-1:0]     reg_addr_o;
  logic [7:0]            reg_wdata_o;
  logic [NUM_CH*8-1:0]   reg_rdata_i;
  logic [NUM_CH-1:0]     irq_ch_i;
  logic                  irq_o;

  int n_vec = 0;
  int n_err = 0;
  int n_abort_hits = 0;

  can_apb_bridge_mc_if s_apb ();

  can_apb_bridge_mc #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .CH_WIN_LOG2 (CH_WIN_LOG2),
    .RD_LAT      (RD_LAT)
  ) dut (
    .aclk        (aclk),
    .arst        (arst),
    .s_apb       (s_apb),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_rdata_i (reg_rdata_i),
    .irq_ch_i    (irq_ch_i),
    .irq_o       (irq_o)
  );

  always #5 aclk = ~aclk;

  // Two-stage register-read model
  logic [7:0] p1 [NUM_CH];
  logic [7:0] p2 [NUM_CH];
  always @(posedge aclk) begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      p1[c] <= reg_re_o[c] ? (reg_addr_o ^ ((c == 0) ? 8'h5A : 8'hA5)) : 8'h00;
      p2[c] <= p1[c];
    end
  end
  always_comb begin
    reg_rdata_i = '0;
    for (int c = 0; c < int'(NUM_CH); c++) reg_rdata_i[8*c +: 8] = p2[c];
  end

  // Per-cycle strobe invariants and aborted-lane watch
  always @(negedge aclk) begin
    n_vec++;
    assert ($onehot0({reg_we_o, reg_re_o})) else begin
      n_err++;
      $error("FAIL strobe_onehot observed=%b expected=at most one bit", {reg_we_o, reg_re_o});
    end
    if (reg_we_o == '0 && reg_re_o == '0) begin
      n_vec++;
      assert ({reg_addr_o, reg_wdata_o} === 16'h0000) else begin
        n_err++;
        $error("FAIL idle_bus observed=0x%0h expected=0x0", {reg_addr_o, reg_wdata_o});
      end
    end
    if (reg_we_o != '0 && (reg_addr_o == 8'h22 || reg_addr_o == 8'h23)) n_abort_hits++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Setup phase then access phase; returns in cycle 0 (penable just raised)
  task automatic apb_start(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    s_apb.paddr   = a;
    s_apb.pwrite  = w;
    s_apb.pwdata  = d;
    s_apb.pstrb   = s;
    s_apb.psel    = 1'b1;
    s_apb.penable = 1'b0;
    tick();
    s_apb.penable = 1'b1;
  endtask

  task automatic apb_end();
    s_apb.psel    = 1'b0;
    s_apb.penable = 1'b0;
  endtask

  task automatic run_to_ready(input int max_cyc, output int cyc, output logic [31:0] rd, output logic err);
    cyc = -1;
    rd  = '0;
    err = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (s_apb.pready === 1'b1) begin
        cyc = i;
        rd  = s_apb.prdata;
        err = s_apb.pslverr;
        break;
      end
    end
  endtask

  // Full transfer with expected completion cycle, read data and error flag
  task automatic xfer(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input int exp_cyc, input logic [31:0] exp_rd, input logic exp_err);
    int          cyc;
    logic [31:0] rd;
    logic        err;
    apb_start(a, w, d, s);
    run_to_ready(20, cyc, rd, err);
    chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_prdata"}, rd, exp_rd);
    chk({tag, "_pslverr"}, 32'(err), 32'(exp_err));
    apb_end();
  endtask

  initial begin
    int          cyc;
    logic [31:0] rd;
    logic        err;
    logic [1:0]  exp_re;

    arst = 1'b0;
    irq_ch_i = 2'b01;
    s_apb.paddr = '0; s_apb.psel = 1'b0; s_apb.penable = 1'b0; s_apb.pwrite = 1'b0;
    s_apb.pwdata = '0; s_apb.pstrb = '0; s_apb.pprot = '0;
    #1 arst = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_pready", 32'(s_apb.pready), 32'd0);
    chk("rst_pslverr", 32'(s_apb.pslverr), 32'd0);
    chk("rst_prdata", s_apb.prdata, 32'd0);
    chk("rst_we_re", 32'({reg_we_o, reg_re_o}), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    arst = 1'b0;
    tick();
    chk("irq_after_rst", 32'(irq_o), 32'd1);
    irq_ch_i = 2'b00;
    tick();
    chk("irq_clear", 32'(irq_o), 32'd0);

    // Sparse-strobe write to channel 1
    apb_start(32'h0000_0410, 1'b1, 32'hA1B2_C3D4, 4'b0101);
    tick();
    chk("w1_c1_we", 32'(reg_we_o), 32'h2);
    chk("w1_c1_addr", 32'(reg_addr_o), 32'h10);
    chk("w1_c1_data", 32'(reg_wdata_o), 32'hD4);
    tick();
    chk("w1_c2_we", 32'(reg_we_o), 32'h2);
    chk("w1_c2_addr", 32'(reg_addr_o), 32'h12);
    chk("w1_c2_data", 32'(reg_wdata_o), 32'hB2);
    tick();
    chk("w1_c3_pready", 32'(s_apb.pready), 32'd1);
    chk("w1_c3_pslverr", 32'(s_apb.pslverr), 32'd0);
    chk("w1_c3_we", 32'(reg_we_o), 32'd0);
    apb_end();
    tick();
    chk("w1_c4_pready", 32'(s_apb.pready), 32'd0);

    // Read channel 0, lane-by-lane timing
    apb_start(32'h0000_0008, 1'b0, 32'h0, 4'b0000);
    for (int c = 1; c <= 13; c++) begin
      tick();
      exp_re = ((c % 3) == 1 && c <= 10) ? 2'b01 : 2'b00;
      chk("r0_re", 32'(reg_re_o), 32'(exp_re));
      if (exp_re != 2'b00) chk("r0_addr", 32'(reg_addr_o), 32'h08 + 32'((c - 1) / 3));
      chk("r0_pready", 32'(s_apb.pready), 32'(c == 13));
    end
    chk("r0_prdata", s_apb.prdata, 32'h5150_5352);
    chk("r0_pslverr", 32'(s_apb.pslverr), 32'd0);
    apb_end();
    tick();
    chk("r0_prdata_clr", s_apb.prdata, 32'd0);

    // Read channel 1
    xfer("r1", 32'h0000_0404, 1'b0, 32'h0, 4'b0000, 13, 32'hA2A3_A0A1, 1'b0);

    // Out-of-range channel, read and write
    xfer("err_rd", 32'h0000_0C00, 1'b0, 32'h0, 4'b0000, 1, 32'h0, 1'b1);
    xfer("err_wr", 32'h0000_0C04, 1'b1, 32'hFFFF_FFFF, 4'b1111, 1, 32'h0, 1'b1);

`ifdef CAN_APB_IRQ_CTRL_EN
    // IRQ control window
    xfer("mask_rst", 32'h0000_0804, 1'b0, 32'h0, 4'b0000, 1, 32'h3, 1'b0);
    xfer("mask_wr", 32'h0000_0804, 1'b1, 32'h1, 4'b0001, 1, 32'h0, 1'b0);
    irq_ch_i = 2'b10;
    tick();
    chk("irq_masked_a", 32'(irq_o), 32'd0);
    tick();
    chk("irq_masked_b", 32'(irq_o), 32'd0);
    xfer("pend_rd", 32'h0000_0800, 1'b0, 32'h0, 4'b0000, 1, 32'h2, 1'b0);
    xfer("pend_wr", 32'h0000_0800, 1'b1, 32'hFF, 4'b1111, 1, 32'h0, 1'b0);
    xfer("mask_rd", 32'h0000_0804, 1'b0, 32'h0, 4'b0000, 1, 32'h1, 1'b0);
    xfer("ctl_other", 32'h0000_0808, 1'b0, 32'h0, 4'b0000, 1, 32'h0, 1'b0);
    irq_ch_i = 2'b11;
    chk("irq_pre", 32'(irq_o), 32'd0);
    tick();
    chk("irq_unmasked", 32'(irq_o), 32'd1);
    irq_ch_i = 2'b01;
    tick();
    xfer("mask_clr", 32'h0000_0804, 1'b1, 32'h0, 4'b0001, 1, 32'h0, 1'b0);
    chk("irq_mask_done", 32'(irq_o), 32'd1);
    tick();
    chk("irq_mask_after", 32'(irq_o), 32'd0);
    xfer("mask_nostrb", 32'h0000_0804, 1'b1, 32'hFF, 4'b0000, 1, 32'h0, 1'b0);
    xfer("mask_rd0", 32'h0000_0804, 1'b0, 32'h0, 4'b0000, 1, 32'h0, 1'b0);
    xfer("mask_ff", 32'h0000_0804, 1'b1, 32'hFF, 4'b0001, 1, 32'h0, 1'b0);
    xfer("mask_rd3", 32'h0000_0804, 1'b0, 32'h0, 4'b0000, 1, 32'h3, 1'b0);
    irq_ch_i = 2'b00;
    tick();
`else
    // Control window absent: error, plain OR interrupt
    xfer("ctl_err", 32'h0000_0800, 1'b0, 32'h0, 4'b0000, 1, 32'h0, 1'b1);
    irq_ch_i = 2'b10;
    tick();
    chk("irq_or", 32'(irq_o), 32'd1);
    irq_ch_i = 2'b00;
    tick();
    chk("irq_or_clr", 32'(irq_o), 32'd0);
`endif

    // Reset in cycle 2 of a 4-strobe write
    apb_start(32'h0000_0020, 1'b1, 32'h4433_2211, 4'b1111);
    tick();
    chk("ab_c1_addr", 32'(reg_addr_o), 32'h20);
    chk("ab_c1_data", 32'(reg_wdata_o), 32'h11);
    tick();
    chk("ab_c2_addr", 32'(reg_addr_o), 32'h21);
    chk("ab_c2_data", 32'(reg_wdata_o), 32'h22);
    apb_end();
    arst = 1'b1;
    #1;
    chk("ab_rst_we", 32'(reg_we_o), 32'd0);
    chk("ab_rst_bus", 32'({reg_addr_o, reg_wdata_o}), 32'd0);
    chk("ab_rst_pready", 32'(s_apb.pready), 32'd0);
    tick(); tick();
    arst = 1'b0;
    tick(); tick();
    apb_start(32'h0000_0030, 1'b1, 32'hDDCC_BBAA, 4'b1000);
    tick();
    chk("ab_new_we", 32'(reg_we_o), 32'h1);
    chk("ab_new_addr", 32'(reg_addr_o), 32'h33);
    chk("ab_new_data", 32'(reg_wdata_o), 32'hDD);
    tick();
    chk("ab_new_pready", 32'(s_apb.pready), 32'd1);
    apb_end();
    tick();
    chk("ab_no_late_lanes", 32'(n_abort_hits), 32'd0);

    // Back-to-back: empty-strobe write then read accepted in cycle 3
    xfer("b2b_wr", 32'h0000_0404, 1'b1, 32'h1234_5678, 4'b0000, 1, 32'h0, 1'b0);
    tick();
    xfer("b2b_rd", 32'h0000_0404, 1'b0, 32'h0, 4'b0000, 13, 32'hA2A3_A0A1, 1'b0);

    // psel dropped mid-sequence: read still completes once
    tick();
    apb_start(32'h0000_0000, 1'b0, 32'h0, 4'b0000);
    tick();
    apb_end();
    run_to_ready(20, cyc, rd, err);
    chk("pv_cyc", 32'(cyc + 1), 32'd13);
    chk("pv_prdata", rd, 32'h5958_5B5A);
    tick();
    chk("pv_single", 32'(s_apb.pready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
